mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Parameter: DATA_W, default 32, memory word width; only 32 is supported.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 if_valid  input  1  fetch read request; if_addr  input  ADDR_W  fetch byte address.
REQ-007 if_ready  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid; if_rdata  output  DATA_W  fetch read data.
REQ-009 d_valid  input  1  load/store request; d_we  input  1  1 = store.
REQ-010 d_addr  input  ADDR_W  data byte address; d_be  input  4  store byte enables; d_wdata  input  DATA_W  store data.
REQ-011 d_ready  output  1  data request accepted this cycle.
REQ-012 d_rvalid  output  1  data response (load data or store ack); d_rdata  output  DATA_W  load data; d_err  output  1  data response is a misalignment error.
REQ-013 mem_en, mem_we  output  1 each  memory port strobes; mem_addr  output  ADDR_W-2  word address; mem_be  output  4  byte enables; mem_wdata  output  DATA_W  write data.
REQ-014 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after mem_en.

Function
REQ-015 One request is granted per cycle; a grant asserts mem_en and the winner's ready in the same cycle, combinationally.
REQ-016 A requester holds valid and its request fields stable until ready; a held request is granted at the latest on the second cycle after valid rises.
REQ-017 With a single requester valid, that requester is granted immediately.
REQ-018 With both valid, the winner is chosen by a round-robin pointer: the winner is the port not granted last; after reset the data port wins first.
REQ-019 The pointer updates only on a cycle with a grant.
REQ-020 Response timing: a grant in cycle N produces the owner's rvalid in cycle N+1 for exactly one cycle; rdata equals mem_rdata in N+1.
REQ-021 Throughput: a new grant in cycle N+1 is permitted, giving back-to-back throughput of one access per cycle.
REQ-022 Response owner tracking: a registered owner field (IF, D, or NONE) routes each response to the correct port.
REQ-023 The non-owner's rvalid is 0.
REQ-024 Unrouted rdata outputs hold their previous value.
REQ-025 Fetch grants drive mem_we=0 and mem_be=4'b1111.
REQ-026 Data grants drive mem_we=d_we and mem_be=d_be; mem_addr is addr[ADDR_W-1:2].
REQ-027 Misalignment: a data request with d_addr[1:0]!=0 is accepted (d_ready=1) with mem_en=0.
REQ-028 A misaligned data request produces d_rvalid=1 and d_err=1 in the next cycle.
REQ-029 Because a misaligned request does not use the memory, a valid fetch request is granted in that same cycle.
REQ-030 A store produces d_rvalid=1 with d_err=0 at N+1; d_rdata is don't-care for stores.
REQ-031 Fetch misalignment is not checked; if_addr[1:0] is ignored.
REQ-032 No response back-pressure: requesters accept rvalid unconditionally.

Reset
REQ-033 While rst=1: ready, rvalid, d_err, mem_en and mem_we are 0; the owner field is NONE; the pointer favours the data port.
REQ-034 Reset mid-transaction discards the pending response: no rvalid is emitted in the cycle after reset deasserts.
REQ-035 The first grant may occur in the first cycle with rst=0.

Structure
REQ-036 Package rv holds: enum arb_owner_e {OWN_NONE, OWN_IF, OWN_D}; constant MEM_BE_W=4; a packed struct mem_req_t {we, addr, be, wdata}.
REQ-037 Sub-module rr_arbiter2 (two-way round-robin: req[1:0], grant[1:0], pointer register, advance on grant) is instantiated once.
REQ-038 No other sub-modules; mem_arbiter connects between the program counter/imem path, the decoder data path and a single-port BRAM.

Verification
REQ-039 Reset, then if_valid only, if_addr=0x100 -> mem_en=1 and mem_addr=0x40 in cycle 0; if_rvalid=1 with memory word 0x40 in cycle 1.
REQ-040 if_valid and d_valid both held from reset -> grant order D, IF, D, IF; one response per cycle, each to the correct port.
REQ-041 Store d_addr=0x8, d_be=4'b0011, d_wdata=0xDEADBEEF, then load 0x8 -> store ack, then d_rdata shows low halfword 0xBEEF merged with the old upper halfword.
REQ-042 Data load d_addr=0x6 with if_valid also high -> d_ready=1 with mem_en for fetch only; next cycle d_rvalid=1, d_err=1 and if_rvalid=1.
REQ-043 Assert rst in the cycle after a fetch grant -> no if_rvalid on reset release; the next grant goes to D if both are valid.
REQ-044 Random valid stimulus for 10k cycles -> scoreboard shows no lost, duplicated or misrouted responses, and no request waits more than one cycle after becoming eligible.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: response owner tag and the
// memory request bundle driven onto the single-port BRAM.
package rv;

  localparam int unsigned MEM_BE_W       = 4;
  localparam int unsigned MEM_DATA_W     = 32;
  // Widest word address the request bundle can carry; narrower buses zero-extend.
  localparam int unsigned MEM_ADDR_MAX_W = 62;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_e;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_MAX_W-1:0] addr;
    logic [MEM_BE_W-1:0]       be;
    logic [MEM_DATA_W-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// requester that was not granted last. The pointer moves only on a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  // 1: req_i[1] wins the next tie
  logic prio_hi_q, prio_hi_d;

  always_comb begin
    grant_o   = req_i;
    prio_hi_d = prio_hi_q;
    if (req_i == 2'b11) begin
      grant_o = prio_hi_q ? 2'b10 : 2'b01;
    end
    if (grant_o[0]) begin
      prio_hi_d = 1'b1;
    end else if (grant_o[1]) begin
      prio_hi_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_hi_q <= 1'b1;
    end else begin
      prio_hi_q <= prio_hi_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port BRAM between instruction fetch and load/store traffic,
// one access per cycle, responses routed back one cycle later by owner tag.
module mem_arbiter
  import rv::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_valid,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [MEM_BE_W-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [MEM_BE_W-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic       d_mis, d_mem_req;
  logic [1:0] req, grant;
  mem_req_t   mreq;
  arb_owner_e owner_q, owner_d;
  logic       err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic       unused_addr;

  // Misaligned data requests never touch memory, so they stay out of arbitration.
  assign d_mis     = d_valid & (d_addr[1:0] != 2'b00) & ~rst;
  assign d_mem_req = d_valid & (d_addr[1:0] == 2'b00);
  assign req       = rst ? 2'b00 : {d_mem_req, if_valid};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .grant_o(grant)
  );

  always_comb begin
    mreq    = '0;
    owner_d = OWN_NONE;
    err_d   = d_mis;
    if (grant[1]) begin
      mreq.we    = d_we;
      mreq.addr  = MEM_ADDR_MAX_W'(d_addr[ADDR_W-1:2]);
      mreq.be    = d_be;
      mreq.wdata = d_wdata;
      owner_d    = OWN_D;
    end else if (grant[0]) begin
      mreq.addr  = MEM_ADDR_MAX_W'(if_addr[ADDR_W-1:2]);
      mreq.be    = '1;
      owner_d    = OWN_IF;
    end
  end

  assign mem_en    = |grant;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr[ADDR_W-3:0];
  assign mem_be    = mreq.be;
  assign mem_wdata = mreq.wdata;

  assign if_ready  = grant[0];
  assign d_ready   = grant[1] | d_mis;

  // A response pending across reset is dropped by gating on rst as well.
  assign if_rvalid = (owner_q == OWN_IF) & ~rst;
  assign d_rvalid  = ((owner_q == OWN_D) | err_q) & ~rst;
  assign d_err     = err_q & ~rst;
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = ((owner_q == OWN_D) & ~rst) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

  assign unused_addr = ^{if_addr[1:0], mreq.addr[MEM_ADDR_MAX_W-1:ADDR_W-2]};

endmodule
